// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - state encoding and counter sizing shared by the shift-add multiplier.
package mul_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_TEST  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } mul_state_t;

    function automatic int calc_cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/mul_control_fsm.sv
// rtl/mul_control_fsm.sv - multiplier control FSM; Z (remaining bits zero) is honoured only with MUL_EARLY_TERM_EN.
module mul_control_fsm
    import mul_pkg::*;
(
    input  logic Clk,
    input  logic Reset,
    input  logic St,
    input  logic M,
    input  logic K,
    input  logic Z,
    output logic Load,
    output logic Sh,
    output logic Ad,
    output logic Done,
    output logic Busy
);

    mul_state_t state, state_nxt;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

`ifndef MUL_EARLY_TERM_EN
    logic unused_z;
    assign unused_z = Z;
`endif

    always_comb begin
        state_nxt = state;
        Load      = 1'b0;
        Sh        = 1'b0;
        Ad        = 1'b0;
        Done      = 1'b0;
        Busy      = (state == S_TEST) || (state == S_SHIFT);
        case (state)
            S_IDLE: begin
                // Mealy load so the operands are captured on the St-sampling edge itself
                Load = St & Reset;
                if (Load) state_nxt = S_TEST;
            end
            S_TEST: begin
`ifdef MUL_EARLY_TERM_EN
                if (Z) begin
                    Sh        = 1'b1;
                    state_nxt = S_DONE;
                end else
`endif
                if (M) begin
                    Ad        = 1'b1;
                    state_nxt = S_SHIFT;
                end else begin
                    Sh        = 1'b1;
                    state_nxt = K ? S_DONE : S_TEST;
                end
            end
            S_SHIFT: begin
                Sh        = 1'b1;
                state_nxt = K ? S_DONE : S_TEST;
            end
            S_DONE: begin
                Done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: rtl/shift_add_multiplier.sv
// rtl/shift_add_multiplier.sv - unsigned shift-and-add multiplier datapath plus control FSM.
// MUL_EARLY_TERM_EN adds a bulk shift once all remaining multiplier bits are zero.
module shift_add_multiplier
    import mul_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = calc_cnt_w(WIDTH)
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               St,
    input  logic [WIDTH-1:0]   Mcand,
    input  logic [WIDTH-1:0]   Mplier,
    output logic [2*WIDTH-1:0] Product,
    output logic               Done,
    output logic               Busy,
    output logic               Load,
    output logic               Sh,
    output logic               Ad
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WIDTH);

    // {carry, upper, lower}; the multiplier drains out of lower as the product fills in
    logic [2*WIDTH:0] acc;
    logic [WIDTH-1:0] mcand_q;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] shamt;
    logic             k;
    logic             z;

    assign k       = (count == LAST_CNT);
    assign Product = acc[2*WIDTH-1:0];

`ifdef MUL_EARLY_TERM_EN
    always_comb begin
        z = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            if (i < WIDTH - int'(count) && acc[i]) z = 1'b0;
        end
    end

    // z is never set in SHIFT since bit 0 still holds the 1 that caused the add
    assign shamt = z ? (FULL_CNT - count) : CNT_W'(1);
`else
    assign z     = 1'b0;
    assign shamt = CNT_W'(1);
`endif

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            acc     <= '0;
            mcand_q <= '0;
            count   <= '0;
        end else if (Load) begin
            acc     <= {{(WIDTH + 1){1'b0}}, Mplier};
            mcand_q <= Mcand;
            count   <= '0;
        end else if (Ad) begin
            acc[2*WIDTH:WIDTH] <= {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
        end else if (Sh) begin
            acc   <= acc >> shamt;
            count <= count + shamt;
        end
    end

    mul_control_fsm u_ctrl (
        .Clk   (Clk),
        .Reset (Reset),
        .St    (St),
        .M     (acc[0]),
        .K     (k),
        .Z     (z),
        .Load  (Load),
        .Sh    (Sh),
        .Ad    (Ad),
        .Done  (Done),
        .Busy  (Busy)
    );

endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb/tb_shift_add_multiplier.sv - self-checking bench for shift_add_multiplier at WIDTH=4 and WIDTH=8.
module tb_shift_add_multiplier;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;
    logic        st4, st8;
    logic [3:0]  a4, b4;
    logic [7:0]  p4;
    logic        done4, busy4, load4, sh4, ad4;
    logic [7:0]  a8, b8;
    logic [15:0] p8;
    logic        done8, busy8, load8, sh8, ad8;

    int n_checks = 0;
    int n_fail   = 0;

    shift_add_multiplier #(.WIDTH(4)) dut4 (
        .Clk(clk), .Reset(rstn), .St(st4), .Mcand(a4), .Mplier(b4), .Product(p4),
        .Done(done4), .Busy(busy4), .Load(load4), .Sh(sh4), .Ad(ad4)
    );

    shift_add_multiplier #(.WIDTH(8)) dut8 (
        .Clk(clk), .Reset(rstn), .St(st8), .Mcand(a8), .Mplier(b8), .Product(p8),
        .Done(done8), .Busy(busy8), .Load(load8), .Sh(sh8), .Ad(ad8)
    );

    // Reference: product by plain arithmetic; timing by walking multiplier bits LSB first
    function automatic void model(input int w, input int a, input int b,
                                  output int prod, output int lat, output int nad, output int nsh);
        int cycles;
        cycles = 0;
        prod   = a * b;
        nad    = 0;
        nsh    = 0;
        for (int i = 0; i < w; i++) begin
`ifdef MUL_EARLY_TERM_EN
            if ((b >> i) == 0) begin
                cycles++;
                nsh++;
                break;
            end
`endif
            cycles += ((b >> i) & 1) ? 2 : 1;
            nad    += (b >> i) & 1;
            nsh++;
        end
        lat = cycles + 1;
    endfunction

    function automatic logic [4:0] flags_of(input int w);
        return (w == 4) ? {done4, busy4, load4, sh4, ad4} : {done8, busy8, load8, sh8, ad8};
    endfunction

    function automatic logic [15:0] prod_of(input int w);
        return (w == 4) ? {8'd0, p4} : p8;
    endfunction

    task automatic drive(input int w, input logic s, input logic [7:0] a, input logic [7:0] b);
        if (w == 4) begin
            st4 = s; a4 = a[3:0]; b4 = b[3:0];
        end else begin
            st8 = s; a8 = a; b8 = b;
        end
    endtask

    task automatic run_op(input int w, input int a, input int b, input string tag);
        int ep, el, ea, es;
        int lat, nad, nsh, ndone;
        logic [15:0] got;
        logic [4:0]  f;
        lat = 0; nad = 0; nsh = 0; ndone = 0; got = '0;
        model(w, a, b, ep, el, ea, es);
        @(negedge clk);
        drive(w, 1'b1, 8'(a), 8'(b));
        #1;
        f = flags_of(w);
        n_checks++;
        if (f[2] !== 1'b1) begin n_fail++; $display("FAIL %s load: got %b expected 1", tag, f[2]); end
        @(negedge clk);
        drive(w, 1'b0, 8'($urandom), 8'($urandom));
        for (int c = 1; c <= 2 * w + 3; c++) begin
            f = flags_of(w);
            if (f[4] === 1'b1) begin
                ndone++;
                if (lat == 0) lat = c;
                got = prod_of(w);
            end
            nad += int'(f[0]);
            nsh += int'(f[1]);
            @(negedge clk);
        end
        n_checks++;
        if (got !== 16'(ep)) begin n_fail++; $display("FAIL %s product: got %0d expected %0d", tag, got, ep); end
        n_checks++;
        if (lat != el) begin n_fail++; $display("FAIL %s latency: got %0d expected %0d", tag, lat, el); end
        n_checks++;
        if (ndone != 1) begin n_fail++; $display("FAIL %s done_pulses: got %0d expected 1", tag, ndone); end
        n_checks++;
        if (nad != ea) begin n_fail++; $display("FAIL %s ad_count: got %0d expected %0d", tag, nad, ea); end
        n_checks++;
        if (nsh != es) begin n_fail++; $display("FAIL %s sh_count: got %0d expected %0d", tag, nsh, es); end
        n_checks++;
        if (prod_of(w) !== 16'(ep)) begin
            n_fail++; $display("FAIL %s product_hold: got %0d expected %0d", tag, prod_of(w), ep);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        drive(4, 1'b0, 8'd0, 8'd0);
        drive(8, 1'b0, 8'd0, 8'd0);
        repeat (2) @(negedge clk);
        n_checks++;
        if (p4 !== 8'd0) begin n_fail++; $display("FAIL reset_product4: got %0d expected 0", p4); end
        n_checks++;
        if (p8 !== 16'd0) begin n_fail++; $display("FAIL reset_product8: got %0d expected 0", p8); end
        n_checks++;
        if (flags_of(4) !== 5'b0) begin n_fail++; $display("FAIL reset_flags4: got %b expected 00000", flags_of(4)); end
        n_checks++;
        if (flags_of(8) !== 5'b0) begin n_fail++; $display("FAIL reset_flags8: got %b expected 00000", flags_of(8)); end
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        run_op(4, 13, 11, "13x11");
        run_op(4, 15, 15, "15x15");
        run_op(4, 13, 2, "13x2");
        run_op(4, 13, 0, "13x0");
        run_op(4, 0, 15, "0x15");
    endtask

    task automatic test_width8();
        run_op(8, 255, 255, "w8_255x255");
        run_op(8, 128, 1, "w8_128x1");
        run_op(8, 1, 128, "w8_1x128");
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++) run_op(4, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), "rand4");
        for (int i = 0; i < 6; i++) run_op(8, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), "rand8");
    endtask

    task automatic test_st_while_busy();
        int ep, el, ea, es;
        int lat, ndone;
        logic [7:0] got;
        lat = 0; ndone = 0; got = '0;
        model(4, 13, 11, ep, el, ea, es);
        @(negedge clk);
        drive(4, 1'b1, 8'd13, 8'd11);
        @(negedge clk);
        drive(4, 1'b0, 8'd7, 8'd9);
        for (int c = 1; c <= 11; c++) begin
            if (done4 === 1'b1) begin
                ndone++;
                if (lat == 0) lat = c;
                got = p4;
            end
            drive(4, (c >= 2 && c <= 4), 8'd7, 8'd9);
            @(negedge clk);
        end
        n_checks++;
        if (got !== 8'(ep)) begin n_fail++; $display("FAIL busy_st product: got %0d expected %0d", got, ep); end
        n_checks++;
        if (lat != el || ndone != 1) begin
            n_fail++; $display("FAIL busy_st done: got cycle %0d pulses %0d expected cycle %0d pulses 1", lat, ndone, el);
        end
        n_checks++;
        if (busy4 !== 1'b0) begin n_fail++; $display("FAIL busy_st queued: got busy %b expected 0", busy4); end
    endtask

    task automatic test_back_to_back();
        int a, b, c2, d;
        int p1, l1, p2, l2, ea, es;
        int dq[$];
        int pq[$];
        a = int'($urandom_range(1, 15)); b = int'($urandom_range(0, 15));
        c2 = int'($urandom_range(1, 15)); d = int'($urandom_range(0, 15));
        model(4, a, b, p1, l1, ea, es);
        model(4, c2, d, p2, l2, ea, es);
        @(negedge clk);
        drive(4, 1'b1, 8'(a), 8'(b));
        @(negedge clk);
        drive(4, 1'b1, 8'(c2), 8'(d));
        for (int c = 1; c <= 40; c++) begin
            if (done4 === 1'b1) begin
                dq.push_back(c);
                pq.push_back(int'(p4));
            end
            if (dq.size() == 2) begin
                drive(4, 1'b0, 8'd0, 8'd0);
                break;
            end
            @(negedge clk);
        end
        n_checks++;
        if (dq.size() != 2) begin
            n_fail++; $display("FAIL b2b done_count: got %0d expected 2", dq.size());
        end else begin
            n_checks++;
            if (pq[0] != p1 || pq[1] != p2) begin
                n_fail++; $display("FAIL b2b products: got %0d,%0d expected %0d,%0d", pq[0], pq[1], p1, p2);
            end
            n_checks++;
            if (dq[0] != l1 || dq[1] != l1 + 1 + l2) begin
                n_fail++; $display("FAIL b2b timing: got %0d,%0d expected %0d,%0d", dq[0], dq[1], l1, l1 + 1 + l2);
            end
        end
        repeat (12) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int nd;
        nd = 0;
        @(negedge clk);
        drive(4, 1'b1, 8'd13, 8'd11);
        @(negedge clk);
        drive(4, 1'b0, 8'd13, 8'd11);
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy4 !== 1'b1) begin n_fail++; $display("FAIL midreset busy_before: got %b expected 1", busy4); end
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        n_checks++;
        if (busy4 !== 1'b0 || p4 !== 8'd0 || done4 !== 1'b0) begin
            n_fail++; $display("FAIL midreset state: got busy %b product %0d done %b expected 0 0 0", busy4, p4, done4);
        end
        repeat (12) begin
            @(negedge clk);
            nd += int'(done4);
        end
        n_checks++;
        if (nd != 0) begin n_fail++; $display("FAIL midreset stray_done: got %0d expected 0", nd); end
        run_op(4, 3, 5, "post_reset_3x5");
    endtask

    initial begin
        rstn = 1'b0;
        drive(4, 1'b0, 8'd0, 8'd0);
        drive(8, 1'b0, 8'd0, 8'd0);
        test_reset();
        test_directed();
        test_width8();
        test_random();
        test_st_while_busy();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
